fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined CPU. It sits directly upstream of the IF/ID pipeline register and produces that register's instruction, PC, write and flush inputs.
- Owns the program counter and drives the combinational instruction memory.
- Sequences sequential advance, load-use stalls and taken-branch redirects with a configurable flush window.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, its instruction memory, the hazard/branch logic
// and the IF/ID pipeline register. The master side is the fetch unit itself.
interface fetch_unit_if;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic [31:0] imem_rdata;
  logic [63:0] imem_addr;
  logic [63:0] pc;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        ifid_write;
  logic        ifid_flush;
  logic [31:0] fetch_count;
  logic [1:0]  state_dbg;

  // No valid/ready pair here: the IF/ID register takes ifid_* on a clk edge when
  // ifid_write=1, clears on ifid_flush=1, and holds otherwise. The two never coincide.
  modport master (
    input  stall, br_taken, br_target, imem_rdata,
    output imem_addr, pc, ifid_instr, ifid_pc, ifid_write, ifid_flush, fetch_count, state_dbg
  );

  modport slave (
    output stall, br_taken, br_target, imem_rdata,
    input  imem_addr, pc, ifid_instr, ifid_pc, ifid_write, ifid_flush, fetch_count, state_dbg
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction memory and
// sequences advance, load-use stall and taken-branch redirect with a flush window.
module fetch_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Remaining bubbles after the redirect cycle itself.
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] count_q, count_d;
  logic        write_c, flush_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 4'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    write_c = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      BOOT: begin
        flush_c = 1'b1;
        state_d = RUN;
      end
      RUN, FLUSH: begin
        if (bus.br_taken) begin
          // A redirect wins over stall and restarts the flush window, even mid-flush.
          flush_c = 1'b1;
          pc_d    = {bus.br_target[63:2], 2'b00};
          if (FLUSH_CYCLES <= 1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end else begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (state_q == FLUSH) begin
          flush_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
          end
        end else if (!bus.stall) begin
          write_c = 1'b1;
          pc_d    = pc_q + 64'd4;
          count_d = count_q + 32'd1;
        end
      end
      default: begin
        flush_c = 1'b1;
        state_d = BOOT;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.ifid_pc     = pc_q;
  assign bus.ifid_instr  = bus.imem_rdata;
  assign bus.ifid_write  = write_c;
  assign bus.ifid_flush  = flush_c;
  assign bus.fetch_count = count_q;
  assign bus.state_dbg   = state_q;

  a_write_flush_exclusive: assert property (@(posedge clk) !(write_c && flush_c));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance with a single-bubble redirect, one with a
// three-bubble window; both share the stimulus.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = 64'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] addr);
    return addr[31:0] ^ 32'h1357_9BDF;
  endfunction

  fetch_unit_if ifa ();
  fetch_unit_if ifb ();

  assign ifa.stall      = stall;
  assign ifa.br_taken   = br_taken;
  assign ifa.br_target  = br_target;
  assign ifa.imem_rdata = instr_of(ifa.imem_addr);
  assign ifb.stall      = stall;
  assign ifb.br_taken   = br_taken;
  assign ifb.br_target  = br_target;
  assign ifb.imem_rdata = instr_of(ifb.imem_addr);

  fetch_unit #(.RESET_PC(64'h0), .FLUSH_CYCLES(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
  fetch_unit #(.RESET_PC(64'h0), .FLUSH_CYCLES(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

  typedef struct {
    logic        chk;
    logic        rst;
    logic        st;
    logic        br;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic        wr;
    logic        fl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic chk, input logic rst, input logic st, input logic br,
                              input logic [63:0] tgt, input logic [63:0] pc, input logic wr,
                              input logic fl, input logic [31:0] cnt);
    vec_t v;
    v.chk = chk; v.rst = rst; v.st = st; v.br = br; v.tgt = tgt;
    v.pc = pc; v.wr = wr; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic br, input logic [63:0] tgt);
    reset     = rst;
    stall     = st;
    br_taken  = br;
    br_target = tgt;
  endtask

  // One cycle on instance B: drive, check pre-edge outputs at negedge, then clock.
  task automatic cycle_b(input string name, input logic chk, input logic rst, input logic st,
                         input logic br, input logic [63:0] tgt, input logic [63:0] epc,
                         input logic ew, input logic ef, input logic [31:0] ecnt,
                         input logic [1:0] est);
    drive(rst, st, br, tgt);
    @(negedge clk);
    if (chk) begin
      cmp({name, ".pc"},    ifb.pc, epc);
      cmp({name, ".instr"}, {32'h0, ifb.ifid_instr}, {32'h0, instr_of(epc)});
      cmp({name, ".write"}, {63'h0, ifb.ifid_write}, {63'h0, ew});
      cmp({name, ".flush"}, {63'h0, ifb.ifid_flush}, {63'h0, ef});
      cmp({name, ".count"}, {32'h0, ifb.fetch_count}, {32'h0, ecnt});
      cmp({name, ".state"}, {62'h0, ifb.state_dbg}, {62'h0, est});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Instance A (FLUSH_CYCLES=1): reset, run, stall, redirect with stall, wrap.
    vt.push_back(mk(0, 1, 0, 0, 64'h0, 64'h0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 64'h0, 64'h0, 0, 1, 0));
    vt.push_back(mk(1, 0, 1, 1, 64'h40, 64'h0, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 0, 64'h0, 64'h0, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 64'h0, 64'h4, 1, 0, 1));
    vt.push_back(mk(1, 0, 1, 0, 64'h0, 64'h8, 0, 0, 2));
    vt.push_back(mk(1, 0, 1, 0, 64'h0, 64'h8, 0, 0, 2));
    vt.push_back(mk(1, 0, 1, 0, 64'h0, 64'h8, 0, 0, 2));
    vt.push_back(mk(1, 0, 0, 0, 64'h0, 64'h8, 1, 0, 2));
    vt.push_back(mk(1, 0, 0, 0, 64'h0, 64'hC, 1, 0, 3));
    vt.push_back(mk(1, 0, 1, 1, 64'h103, 64'h10, 0, 1, 4));
    vt.push_back(mk(1, 0, 0, 0, 64'h0, 64'h100, 1, 0, 4));
    vt.push_back(mk(1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h104, 0, 1, 5));
    vt.push_back(mk(1, 0, 0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 5));
    vt.push_back(mk(1, 0, 0, 0, 64'h0, 64'h0, 1, 0, 6));
    vt.push_back(mk(1, 0, 0, 0, 64'h0, 64'h4, 1, 0, 7));

    @(posedge clk);
    #1;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].st, vt[i].br, vt[i].tgt);
      @(negedge clk);
      if (vt[i].chk) begin
        cmp($sformatf("a%0d.pc", i),    ifa.pc, vt[i].pc);
        cmp($sformatf("a%0d.addr", i),  ifa.imem_addr, vt[i].pc);
        cmp($sformatf("a%0d.ifpc", i),  ifa.ifid_pc, vt[i].pc);
        cmp($sformatf("a%0d.instr", i), {32'h0, ifa.ifid_instr}, {32'h0, instr_of(vt[i].pc)});
        cmp($sformatf("a%0d.write", i), {63'h0, ifa.ifid_write}, {63'h0, vt[i].wr});
        cmp($sformatf("a%0d.flush", i), {63'h0, ifa.ifid_flush}, {63'h0, vt[i].fl});
        cmp($sformatf("a%0d.count", i), {32'h0, ifa.fetch_count}, {32'h0, vt[i].cnt});
      end
      @(posedge clk);
      #1;
    end

    // Instance B (FLUSH_CYCLES=3): redirect, stall ignored in flush, re-redirect, reset mid-flush.
    cycle_b("b_rst",   0, 1, 0, 0, 64'h0,   64'h0,   0, 1, 0, 2'd0);
    cycle_b("b_boot",  1, 0, 0, 0, 64'h0,   64'h0,   0, 1, 0, 2'd0);
    cycle_b("b_run0",  1, 0, 0, 0, 64'h0,   64'h0,   1, 0, 0, 2'd1);
    cycle_b("b_br1",   1, 0, 0, 1, 64'h103, 64'h4,   0, 1, 1, 2'd1);
    cycle_b("b_fl1",   1, 0, 1, 0, 64'h0,   64'h100, 0, 1, 1, 2'd2);
    cycle_b("b_br2",   1, 0, 0, 1, 64'h200, 64'h100, 0, 1, 1, 2'd2);
    cycle_b("b_fl2",   1, 0, 0, 0, 64'h0,   64'h200, 0, 1, 1, 2'd2);
    cycle_b("b_fl3",   1, 0, 1, 0, 64'h0,   64'h200, 0, 1, 1, 2'd2);
    cycle_b("b_run1",  1, 0, 0, 0, 64'h0,   64'h200, 1, 0, 1, 2'd1);
    cycle_b("b_br3",   1, 0, 0, 1, 64'h300, 64'h204, 0, 1, 2, 2'd1);
    cycle_b("b_rstfl", 1, 1, 0, 1, 64'h500, 64'h300, 0, 1, 2, 2'd2);
    cycle_b("b_rsted", 1, 1, 0, 0, 64'h0,   64'h0,   0, 1, 0, 2'd0);
    cycle_b("b_boot2", 1, 0, 1, 1, 64'h700, 64'h0,   0, 1, 0, 2'd0);
    cycle_b("b_run2",  1, 0, 0, 0, 64'h0,   64'h0,   1, 0, 0, 2'd1);
    cycle_b("b_run3",  1, 0, 0, 0, 64'h0,   64'h4,   1, 0, 1, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
